pe_sequencer: RTL and testbench
===============================

PE_SEQUENCER -- requirements
Module: pe_sequencer

Interface
REQ-001 Parameters: DATA_WIDTH 20, data word width; ADDR_WIDTH 8, source-memory address width; CNT_WIDTH 8, stream-length width; STRIDE_WIDTH 2; FILTER_SIZE_WIDTH 3.
REQ-002 The block SHALL run on one clock and SHALL use an asynchronous, active-low reset.
REQ-003 Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-low
- cfg_valid  in  1  job descriptor valid
- cfg_ready  out  1  sequencer can accept descriptor
- cfg_mode  in  2  PE mode
- cfg_stride  in  STRIDE_WIDTH  stride
- cfg_filter_size  in  FILTER_SIZE_WIDTH  filter size
- cfg_wr_psum  in  1  job consumes input psums
- cfg_ifmap_len / cfg_filter_len / cfg_psum_len  in  CNT_WIDTH each  word counts
- mem_ren  out  1  source read strobe
- mem_sel  out  2  region: 0 IFMap, 1 Filter, 2 Psum
- mem_addr  out  ADDR_WIDTH  word address within region
- mem_rdata  in  DATA_WIDTH  read data, valid exactly one cycle after mem_ren
- wen_IFMap  out  1, IFMap_in  out  DATA_WIDTH+2, ready_IFMap  in  1  IFMap FIFO write port
- wen_Filter  out  1, Filter_in  out  DATA_WIDTH, ready_Filter  in  1  Filter FIFO write port
- wen_input_Psum  out  1, input_Psum_in  out  DATA_WIDTH, ready_input_Psum  in  1  psum FIFO write port
- Start  out  1  PE start pulse
- mode  out  2, stride  out  STRIDE_WIDTH, filter_size  out  FILTER_SIZE_WIDTH, wr_psum  out  1  latched PE config
- ready  in  1  PE idle; done  in  1  PE job complete
- busy  out  1  job in progress; job_done  out  1  one-cycle completion pulse

Function
REQ-004 States: IDLE, LOAD_IF, LOAD_FI, LOAD_PS, START, WAIT, FIN.
REQ-005 IDLE: cfg_ready=1; on cfg_valid, latch all cfg_* fields, go to LOAD_IF; busy=1 in all non-IDLE states.
REQ-006 Phase order LOAD_IF -> LOAD_FI -> LOAD_PS -> START; any phase of length 0 is skipped; LOAD_PS is skipped when latched wr_psum=0.
REQ-007 ifmap_len=0: skip all loads and START, go directly to FIN.
REQ-008 Each phase SHALL read addresses 0..len-1 of its region in order, with mem_sel constant for the phase.
REQ-009 mem_ren SHALL be asserted only when target FIFO ready=1, the skid register is empty, and words remain; the matching FIFO write SHALL occur on the next cycle.
REQ-010 If FIFO ready=0 on the write cycle, the word SHALL be held in a 1-entry skid register and written on the first cycle ready=1; no read is issued while the skid register is full; no word is lost or duplicated.
REQ-011 Sustained throughput SHALL be one word per cycle while ready stays 1.
REQ-012 IFMap tag bits [DATA_WIDTH+1:DATA_WIDTH]: 2'b10 first word, 2'b01 last word, 2'b11 when len=1, 2'b00 otherwise; low bits carry mem_rdata.
REQ-013 A phase SHALL end the cycle after its last FIFO write.
REQ-014 START: wait until ready=1, then assert Start for exactly one cycle and go to WAIT.
REQ-015 mode/stride/filter_size/wr_psum outputs SHALL hold the latched values from LOAD_IF entry until return to IDLE.
REQ-016 WAIT: on done=1 go to FIN; done in any other state SHALL be ignored.
REQ-017 FIN: pulse job_done for one cycle, return to IDLE; cfg_valid SHALL be ignored outside IDLE.

Reset
REQ-018 While rst=0: state IDLE; all strobes (mem_ren, wen_*, Start, job_done) 0; busy 0; cfg_ready 1; counters, skid register, latched config and data outputs 0.
REQ-019 Reset mid-job SHALL abort immediately with no further FIFO writes or Start.

Verification
REQ-020 Job ifmap_len=10, filter_len=6, wr_psum=0, mode=3, stride=1, filter_size=6, FIFOs always ready -> 10 IFMap writes tagged 10,00x8,01; 6 Filter writes; 0 psum writes; one Start; job_done one cycle after done.
REQ-021 Same job, ready_IFMap low for 3 cycles after the 4th write -> skid holds word 5; IFMap FIFO receives addresses 0..9 exactly once, in order.
REQ-022 ifmap_len=1, filter_len=1, wr_psum=1, psum_len=4 -> single IFMap write tagged 11; 4 psum writes from region 2; then Start.
REQ-023 ifmap_len=0 -> no mem_ren, no Start; job_done 2 cycles after cfg accept.
REQ-024 rst pulled low during LOAD_FI -> all outputs at reset values asynchronously; new job after release runs from address 0.
REQ-025 ready=0 at START for 5 cycles -> Start held off, then exactly one pulse; done pulsed during LOAD_IF -> ignored.

Source files
------------

// File: rtl/pe_sequencer.sv
// -----------------------------------------------------------------------------
// pe_sequencer
//
// Job sequencer in front of a processing element (PE). One job descriptor is
// accepted in IDLE. The sequencer then streams the IFMap, Filter and (optional)
// input-psum words from a source memory into the PE's three input FIFOs, starts
// the PE, waits for it to finish and pulses job_done.
//
// The source memory has a fixed one-cycle read latency. A read is only issued
// when the target FIFO is ready. If that FIFO drops ready while the word is in
// flight, the word parks in a one-entry skid register. Streaming stalls until
// the skid register drains, so no word is lost or duplicated. With ready held
// high the stream runs at one word per cycle.
//
// Ports
//   clk, rst            clock, asynchronous active-low reset
//   cfg_*               job descriptor handshake (cfg_valid / cfg_ready) and
//                       its fields
//   mem_ren/sel/addr    source read request (sel: 0 IFMap, 1 Filter, 2 Psum)
//   mem_rdata           read data, valid the cycle after mem_ren
//   wen_IFMap, IFMap_in, ready_IFMap
//                       IFMap FIFO write port; IFMap_in[DW+1:DW] is the
//                       first/last tag
//   wen_Filter, Filter_in, ready_Filter
//                       Filter FIFO write port
//   wen_input_Psum, input_Psum_in, ready_input_Psum
//                       psum FIFO write port
//   Start               one-cycle PE start pulse
//   mode, stride, filter_size, wr_psum
//                       job configuration presented to the PE
//   ready, done         PE idle / PE job complete
//   busy, job_done      job in progress / one-cycle completion pulse
// -----------------------------------------------------------------------------
module pe_sequencer #(
    parameter int DATA_WIDTH        = 20,
    parameter int ADDR_WIDTH        = 8,
    parameter int CNT_WIDTH         = 8,
    parameter int STRIDE_WIDTH      = 2,
    parameter int FILTER_SIZE_WIDTH = 3
) (
    input  logic                         clk,
    input  logic                         rst,

    input  logic                         cfg_valid,
    output logic                         cfg_ready,
    input  logic [1:0]                   cfg_mode,
    input  logic [STRIDE_WIDTH-1:0]      cfg_stride,
    input  logic [FILTER_SIZE_WIDTH-1:0] cfg_filter_size,
    input  logic                         cfg_wr_psum,
    input  logic [CNT_WIDTH-1:0]         cfg_ifmap_len,
    input  logic [CNT_WIDTH-1:0]         cfg_filter_len,
    input  logic [CNT_WIDTH-1:0]         cfg_psum_len,

    output logic                         mem_ren,
    output logic [1:0]                   mem_sel,
    output logic [ADDR_WIDTH-1:0]        mem_addr,
    input  logic [DATA_WIDTH-1:0]        mem_rdata,

    output logic                         wen_IFMap,
    output logic [DATA_WIDTH+1:0]        IFMap_in,
    input  logic                         ready_IFMap,
    output logic                         wen_Filter,
    output logic [DATA_WIDTH-1:0]        Filter_in,
    input  logic                         ready_Filter,
    output logic                         wen_input_Psum,
    output logic [DATA_WIDTH-1:0]        input_Psum_in,
    input  logic                         ready_input_Psum,

    output logic                         Start,
    output logic [1:0]                   mode,
    output logic [STRIDE_WIDTH-1:0]      stride,
    output logic [FILTER_SIZE_WIDTH-1:0] filter_size,
    output logic                         wr_psum,
    input  logic                         ready,
    input  logic                         done,

    output logic                         busy,
    output logic                         job_done
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LOAD_IF = 3'd1,
        S_LOAD_FI = 3'd2,
        S_LOAD_PS = 3'd3,
        S_START   = 3'd4,
        S_WAIT    = 3'd5,
        S_FIN     = 3'd6
    } state_t;

    localparam logic [1:0] SEL_IFMAP  = 2'd0;
    localparam logic [1:0] SEL_FILTER = 2'd1;
    localparam logic [1:0] SEL_PSUM   = 2'd2;

    // -------------------------------------------------------------------------
    // State and latched job descriptor
    // -------------------------------------------------------------------------
    state_t                         r_state;
    logic [1:0]                     r_mode;
    logic [STRIDE_WIDTH-1:0]        r_stride;
    logic [FILTER_SIZE_WIDTH-1:0]   r_filter_size;
    logic                           r_wr_psum;
    logic [CNT_WIDTH-1:0]           r_if_len;
    logic [CNT_WIDTH-1:0]           r_fi_len;
    logic [CNT_WIDTH-1:0]           r_ps_len;

    // Per-phase streaming state. r_rd_cnt doubles as the read address.
    logic [CNT_WIDTH-1:0]           r_rd_cnt;
    logic [CNT_WIDTH-1:0]           r_wr_cnt;
    logic                           r_pend_p1;
    logic                           r_skid_vld;
    logic [DATA_WIDTH-1:0]          r_skid_data;
    logic                           r_start;

    // -------------------------------------------------------------------------
    // Helper functions
    // -------------------------------------------------------------------------

    // IFMap tag: bit 1 marks the first word and bit 0 marks the last word.
    // A one-word stream therefore gets 2'b11.
    function automatic logic [1:0] f_ifmap_tag(
        input logic [CNT_WIDTH-1:0] idx,
        input logic [CNT_WIDTH-1:0] len
    );
        logic w_first;
        logic w_last;
        w_first = (idx == '0);
        w_last  = (idx == (len - CNT_WIDTH'(1)));
        return {w_first, w_last};
    endfunction

    // Phase that follows the Filter load. Psum is skipped when the job does
    // not consume psums or has none to load.
    function automatic state_t f_after_filter(
        input logic                 wr_ps,
        input logic [CNT_WIDTH-1:0] ps_len
    );
        if (wr_ps && (ps_len != '0)) begin
            return S_LOAD_PS;
        end
        return S_START;
    endfunction

    // Phase that follows the IFMap load. Empty phases are skipped outright.
    function automatic state_t f_after_ifmap(
        input logic [CNT_WIDTH-1:0] fi_len,
        input logic                 wr_ps,
        input logic [CNT_WIDTH-1:0] ps_len
    );
        if (fi_len != '0) begin
            return S_LOAD_FI;
        end
        return f_after_filter(wr_ps, ps_len);
    endfunction

    // -------------------------------------------------------------------------
    // Phase decode: length, region and FIFO readiness of the active phase
    // -------------------------------------------------------------------------
    logic                           w_in_load;
    logic [CNT_WIDTH-1:0]           w_len;
    logic [1:0]                     w_sel;
    logic                           w_fifo_rdy;

    always_comb begin
        w_in_load  = 1'b0;
        w_len      = '0;
        w_sel      = SEL_IFMAP;
        w_fifo_rdy = 1'b0;
        case (r_state)
            S_LOAD_IF: begin
                w_in_load  = 1'b1;
                w_len      = r_if_len;
                w_sel      = SEL_IFMAP;
                w_fifo_rdy = ready_IFMap;
            end
            S_LOAD_FI: begin
                w_in_load  = 1'b1;
                w_len      = r_fi_len;
                w_sel      = SEL_FILTER;
                w_fifo_rdy = ready_Filter;
            end
            S_LOAD_PS: begin
                w_in_load  = 1'b1;
                w_len      = r_ps_len;
                w_sel      = SEL_PSUM;
                w_fifo_rdy = ready_input_Psum;
            end
            default: begin
                w_in_load  = 1'b0;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Stage p0: read issue
    // -------------------------------------------------------------------------
    logic w_more;
    logic w_ren;

    assign w_more = (r_rd_cnt < w_len);
    // No read while the skid register holds a word. This keeps the in-flight
    // word and the skid word mutually exclusive.
    assign w_ren  = w_in_load && w_fifo_rdy && !r_skid_vld && w_more;

    // -------------------------------------------------------------------------
    // Stage p1: FIFO write from returning data or from the skid register
    // -------------------------------------------------------------------------
    logic                  w_have;
    logic                  w_wr;
    logic [DATA_WIDTH-1:0] w_word;
    logic                  w_last_wr;
    logic [1:0]            w_tag;

    assign w_have    = r_pend_p1 || r_skid_vld;
    assign w_wr      = w_in_load && w_have && w_fifo_rdy;
    assign w_word    = r_skid_vld ? r_skid_data : mem_rdata;
    assign w_last_wr = w_wr && (r_wr_cnt == (w_len - CNT_WIDTH'(1)));
    assign w_tag     = f_ifmap_tag(r_wr_cnt, w_len);

    // -------------------------------------------------------------------------
    // Sequencer FSM and datapath registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state       <= S_IDLE;
            r_mode        <= '0;
            r_stride      <= '0;
            r_filter_size <= '0;
            r_wr_psum     <= 1'b0;
            r_if_len      <= '0;
            r_fi_len      <= '0;
            r_ps_len      <= '0;
            r_rd_cnt      <= '0;
            r_wr_cnt      <= '0;
            r_pend_p1     <= 1'b0;
            r_skid_vld    <= 1'b0;
            r_skid_data   <= '0;
            r_start       <= 1'b0;
        end else begin
            r_start   <= 1'b0;
            r_pend_p1 <= w_ren;

            // Park the returning word when its FIFO is not ready and release
            // it once the FIFO accepts it.
            if (w_in_load && r_pend_p1 && !w_fifo_rdy) begin
                r_skid_vld  <= 1'b1;
                r_skid_data <= mem_rdata;
            end else if (w_in_load && r_skid_vld && w_fifo_rdy) begin
                r_skid_vld  <= 1'b0;
            end

            if (w_ren) begin
                r_rd_cnt <= r_rd_cnt + CNT_WIDTH'(1);
            end
            if (w_wr) begin
                r_wr_cnt <= r_wr_cnt + CNT_WIDTH'(1);
            end

            case (r_state)
                S_IDLE: begin
                    if (cfg_valid) begin
                        r_mode        <= cfg_mode;
                        r_stride      <= cfg_stride;
                        r_filter_size <= cfg_filter_size;
                        r_wr_psum     <= cfg_wr_psum;
                        r_if_len      <= cfg_ifmap_len;
                        r_fi_len      <= cfg_filter_len;
                        r_ps_len      <= cfg_psum_len;
                        r_rd_cnt      <= '0;
                        r_wr_cnt      <= '0;
                        r_state       <= S_LOAD_IF;
                    end
                end
                S_LOAD_IF: begin
                    // An empty IFMap means there is no work for the PE at all.
                    if (r_if_len == '0) begin
                        r_state <= S_FIN;
                    end else if (w_last_wr) begin
                        r_rd_cnt <= '0;
                        r_wr_cnt <= '0;
                        r_state  <= f_after_ifmap(r_fi_len, r_wr_psum, r_ps_len);
                    end
                end
                S_LOAD_FI: begin
                    if (w_last_wr) begin
                        r_rd_cnt <= '0;
                        r_wr_cnt <= '0;
                        r_state  <= f_after_filter(r_wr_psum, r_ps_len);
                    end
                end
                S_LOAD_PS: begin
                    if (w_last_wr) begin
                        r_rd_cnt <= '0;
                        r_wr_cnt <= '0;
                        r_state  <= S_START;
                    end
                end
                S_START: begin
                    if (ready) begin
                        r_start <= 1'b1;
                        r_state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (done) begin
                        r_state <= S_FIN;
                    end
                end
                S_FIN: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign cfg_ready = (r_state == S_IDLE);
    assign busy      = (r_state != S_IDLE);
    assign job_done  = (r_state == S_FIN);
    assign Start     = r_start;

    assign mode        = r_mode;
    assign stride      = r_stride;
    assign filter_size = r_filter_size;
    assign wr_psum     = r_wr_psum;

    assign mem_ren  = w_ren;
    assign mem_sel  = w_sel;
    assign mem_addr = ADDR_WIDTH'(r_rd_cnt);

    // Write data is forced to zero when no write is in progress, so stale
    // memory data never shows on the FIFO buses.
    assign wen_IFMap      = w_wr && (r_state == S_LOAD_IF);
    assign wen_Filter     = w_wr && (r_state == S_LOAD_FI);
    assign wen_input_Psum = w_wr && (r_state == S_LOAD_PS);

    assign IFMap_in      = wen_IFMap      ? {w_tag, w_word} : '0;
    assign Filter_in     = wen_Filter     ? w_word          : '0;
    assign input_Psum_in = wen_input_Psum ? w_word          : '0;

endmodule

// File: tb/tb_pe_sequencer.sv
module tb_pe_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        cfg_valid;
    logic        cfg_ready;
    logic [1:0]  cfg_mode;
    logic [1:0]  cfg_stride;
    logic [2:0]  cfg_filter_size;
    logic        cfg_wr_psum;
    logic [7:0]  cfg_ifmap_len;
    logic [7:0]  cfg_filter_len;
    logic [7:0]  cfg_psum_len;
    logic        mem_ren;
    logic [1:0]  mem_sel;
    logic [7:0]  mem_addr;
    logic [19:0] mem_rdata;
    logic        wen_IFMap;
    logic [21:0] IFMap_in;
    logic        ready_IFMap;
    logic        wen_Filter;
    logic [19:0] Filter_in;
    logic        ready_Filter;
    logic        wen_input_Psum;
    logic [19:0] input_Psum_in;
    logic        ready_input_Psum;
    logic        Start;
    logic [1:0]  mode;
    logic [1:0]  stride;
    logic [2:0]  filter_size;
    logic        wr_psum;
    logic        ready;
    logic        done;
    logic        busy;
    logic        job_done;

    pe_sequencer #(
        .DATA_WIDTH(20), .ADDR_WIDTH(8), .CNT_WIDTH(8),
        .STRIDE_WIDTH(2), .FILTER_SIZE_WIDTH(3)
    ) dut (
        .clk(clk), .rst(rst),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_mode(cfg_mode),
        .cfg_stride(cfg_stride), .cfg_filter_size(cfg_filter_size),
        .cfg_wr_psum(cfg_wr_psum), .cfg_ifmap_len(cfg_ifmap_len),
        .cfg_filter_len(cfg_filter_len), .cfg_psum_len(cfg_psum_len),
        .mem_ren(mem_ren), .mem_sel(mem_sel), .mem_addr(mem_addr),
        .mem_rdata(mem_rdata),
        .wen_IFMap(wen_IFMap), .IFMap_in(IFMap_in), .ready_IFMap(ready_IFMap),
        .wen_Filter(wen_Filter), .Filter_in(Filter_in), .ready_Filter(ready_Filter),
        .wen_input_Psum(wen_input_Psum), .input_Psum_in(input_Psum_in),
        .ready_input_Psum(ready_input_Psum),
        .Start(Start), .mode(mode), .stride(stride), .filter_size(filter_size),
        .wr_psum(wr_psum), .ready(ready), .done(done),
        .busy(busy), .job_done(job_done)
    );

    always #5 clk = ~clk;

    // Source memory: word = (region+1)*0x1000 + address, one-cycle latency.
    // Garbage when no read was issued, so a mistimed capture shows up.
    always @(posedge clk) begin
        if (mem_ren) mem_rdata <= 20'((int'(mem_sel) + 1) * 4096 + int'(mem_addr));
        else         mem_rdata <= 20'hBAD00;
    end

    logic [21:0] q_if[$];
    logic [19:0] q_fi[$];
    logic [19:0] q_ps[$];

    int checks = 0;
    int errors = 0;
    int n_if = 0, n_fi = 0, n_ps = 0, n_start = 0, n_jd = 0, n_ren = 0;
    int cyc = 0, if_first_cyc = 0, if_last_cyc = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: pops expected words whenever a FIFO write appears.
    task automatic monitor();
        logic [21:0] e22;
        logic [19:0] e20;
        forever begin
            @(negedge clk);
            cyc++;
            if (!rst) begin
                q_if.delete();
                q_fi.delete();
                q_ps.delete();
            end
            if (mem_ren) n_ren++;
            if (job_done) n_jd++;
            if (Start) begin
                n_start++;
                chk("start_after_loads", 32'(q_if.size() + q_fi.size() + q_ps.size()), 32'd0);
            end
            if (wen_IFMap) begin
                n_if++;
                if (IFMap_in[21]) if_first_cyc = cyc;
                if (IFMap_in[20]) if_last_cyc = cyc;
                chk("ifmap_wen_while_ready", 32'(ready_IFMap), 32'd1);
                if (q_if.size() == 0) chk("ifmap_unexpected_write", 32'(IFMap_in), 32'hFFFFFFFF);
                else begin
                    e22 = q_if.pop_front();
                    chk("ifmap_word", 32'(IFMap_in), 32'(e22));
                end
            end
            if (wen_Filter) begin
                n_fi++;
                chk("filter_wen_while_ready", 32'(ready_Filter), 32'd1);
                if (q_fi.size() == 0) chk("filter_unexpected_write", 32'(Filter_in), 32'hFFFFFFFF);
                else begin
                    e20 = q_fi.pop_front();
                    chk("filter_word", 32'(Filter_in), 32'(e20));
                end
            end
            if (wen_input_Psum) begin
                n_ps++;
                chk("psum_wen_while_ready", 32'(ready_input_Psum), 32'd1);
                if (q_ps.size() == 0) chk("psum_unexpected_write", 32'(input_Psum_in), 32'hFFFFFFFF);
                else begin
                    e20 = q_ps.pop_front();
                    chk("psum_word", 32'(input_Psum_in), 32'(e20));
                end
            end
        end
    endtask

    task automatic push_job(input int il, input int fl, input int wp, input int pl);
        logic [1:0] tag;
        if (il == 0) return;
        for (int i = 0; i < il; i++) begin
            if (il == 1)           tag = 2'b11;
            else if (i == 0)       tag = 2'b10;
            else if (i == il - 1)  tag = 2'b01;
            else                   tag = 2'b00;
            q_if.push_back({tag, 20'(32'h1000 + i)});
        end
        for (int i = 0; i < fl; i++) q_fi.push_back(20'(32'h2000 + i));
        if (wp != 0) for (int i = 0; i < pl; i++) q_ps.push_back(20'(32'h3000 + i));
    endtask

    // Returns #1 after the accepting clock edge.
    task automatic apply_cfg(input int il, input int fl, input int wp, input int pl,
                             input int md, input int st, input int fs);
        int k;
        for (k = 0; k < 200; k++) begin
            if (cfg_ready) break;
            @(posedge clk); #1;
        end
        chk("cfg_ready_timeout", 32'(k < 200), 32'd1);
        cfg_ifmap_len   = 8'(il);
        cfg_filter_len  = 8'(fl);
        cfg_wr_psum     = 1'(wp);
        cfg_psum_len    = 8'(pl);
        cfg_mode        = 2'(md);
        cfg_stride      = 2'(st);
        cfg_filter_size = 3'(fs);
        cfg_valid       = 1'b1;
        @(posedge clk); #1;
        cfg_valid       = 1'b0;
    endtask

    task automatic wait_start(input int s0, input string nm);
        int k;
        for (k = 0; k < 500; k++) begin
            @(posedge clk); #1;
            if (n_start > s0) break;
        end
        chk({nm, "_start_timeout"}, 32'(k < 500), 32'd1);
    endtask

    // PE reports done; job_done must follow in the next cycle only.
    task automatic finish_job(input string nm);
        done = 1'b1;
        @(posedge clk); #1;
        done = 1'b0;
        @(negedge clk);
        chk({nm, "_job_done_pulse"}, 32'(job_done), 32'd1);
        @(negedge clk);
        chk({nm, "_job_done_single"}, 32'({job_done, busy, cfg_ready}), 32'b001);
    endtask

    task automatic drop_ready(input int target);
        for (int k = 0; k < 300; k++) begin
            @(posedge clk); #1;
            if (n_if >= target) begin
                ready_IFMap = 1'b0;
                repeat (3) @(posedge clk);
                #1 ready_IFMap = 1'b1;
                break;
            end
        end
    endtask

    task automatic run_job(input int il, input int fl, input int wp, input int pl,
                           input int md, input int st, input int fs,
                           input int drop, input string nm);
        int s0, jd0, if0, fi0, ps0, r0, tgt;
        @(posedge clk); #1;
        s0 = n_start; jd0 = n_jd; if0 = n_if; fi0 = n_fi; ps0 = n_ps; r0 = n_ren;
        tgt = if0 + drop;
        push_job(il, fl, wp, pl);
        if (drop > 0) begin
            fork
                drop_ready(tgt);
            join_none
        end
        apply_cfg(il, fl, wp, pl, md, st, fs);
        wait_start(s0, nm);
        chk({nm, "_cfg_out"}, 32'({mode, stride, filter_size, wr_psum}),
            32'({2'(md), 2'(st), 3'(fs), 1'(wp)}));
        finish_job(nm);
        @(posedge clk); #1;
        chk({nm, "_n_ifmap"}, 32'(n_if - if0), 32'(il));
        chk({nm, "_n_filter"}, 32'(n_fi - fi0), 32'(fl));
        chk({nm, "_n_psum"}, 32'(n_ps - ps0), 32'((wp != 0) ? pl : 0));
        chk({nm, "_n_reads"}, 32'(n_ren - r0), 32'(il + fl + ((wp != 0) ? pl : 0)));
        chk({nm, "_n_start"}, 32'(n_start - s0), 32'd1);
        chk({nm, "_n_job_done"}, 32'(n_jd - jd0), 32'd1);
        chk({nm, "_queues_drained"}, 32'(q_if.size() + q_fi.size() + q_ps.size()), 32'd0);
    endtask

    task automatic check_reset_outputs(input string nm);
        chk({nm, "_strobes"}, 32'({mem_ren, wen_IFMap, wen_Filter, wen_input_Psum,
                                   Start, job_done, busy}), 32'd0);
        chk({nm, "_cfg_ready"}, 32'(cfg_ready), 32'd1);
        chk({nm, "_cfg_out"}, 32'({mode, stride, filter_size, wr_psum}), 32'd0);
        chk({nm, "_ifmap_data"}, 32'(IFMap_in), 32'd0);
        chk({nm, "_other_data"}, 32'({Filter_in, input_Psum_in}), 32'd0);
        chk({nm, "_mem_addr"}, 32'({mem_sel, mem_addr}), 32'd0);
    endtask

    initial begin
        int s0, jd0, r0, fi0, k;
        rst = 1'b0;
        cfg_valid = 1'b0; cfg_mode = '0; cfg_stride = '0; cfg_filter_size = '0;
        cfg_wr_psum = 1'b0; cfg_ifmap_len = '0; cfg_filter_len = '0; cfg_psum_len = '0;
        ready_IFMap = 1'b1; ready_Filter = 1'b1; ready_input_Psum = 1'b1;
        ready = 1'b1; done = 1'b0;

        fork
            monitor();
        join_none

        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("reset");
        @(posedge clk); #1 rst = 1'b1;

        // Basic job, FIFOs always ready
        run_job(10, 6, 0, 0, 3, 1, 6, 0, "job_basic");
        chk("job_basic_ifmap_throughput", 32'(if_last_cyc - if_first_cyc), 32'd9);

        // IFMap FIFO back-pressure right after the 4th write
        run_job(10, 6, 0, 0, 3, 1, 6, 4, "job_skid");

        // Single-word IFMap plus psum phase
        run_job(1, 1, 1, 4, 1, 2, 3, 0, "job_psum");

        // Empty filter phase skipped
        run_job(3, 0, 1, 2, 2, 0, 1, 0, "job_nofilter");

        // Empty IFMap: straight to completion
        @(posedge clk); #1;
        s0 = n_start; jd0 = n_jd; r0 = n_ren;
        apply_cfg(0, 3, 1, 2, 1, 1, 1);
        @(negedge clk);
        chk("empty_job_done_cycle1", 32'(job_done), 32'd0);
        @(negedge clk);
        chk("empty_job_done_cycle2", 32'(job_done), 32'd1);
        @(negedge clk);
        chk("empty_idle_again", 32'({job_done, busy, cfg_ready}), 32'b001);
        @(posedge clk); #1;
        chk("empty_no_reads", 32'(n_ren - r0), 32'd0);
        chk("empty_no_start", 32'(n_start - s0), 32'd0);
        chk("empty_one_job_done", 32'(n_jd - jd0), 32'd1);

        // Reset during the Filter phase
        @(posedge clk); #1;
        push_job(10, 6, 0, 0);
        apply_cfg(10, 6, 0, 0, 2, 3, 5);
        s0 = n_start;
        for (k = 0; k < 300; k++) begin
            @(posedge clk); #1;
            if (mem_ren && (mem_sel == 2'd1)) break;
        end
        chk("abort_reach_filter", 32'(k < 300), 32'd1);
        @(posedge clk); #2;
        rst = 1'b0;
        #1;
        check_reset_outputs("abort_async");
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("abort_held");
        chk("abort_no_start", 32'(n_start - s0), 32'd0);
        rst = 1'b1;
        run_job(10, 6, 0, 0, 2, 3, 5, 0, "job_after_abort");

        // PE busy at START; stray done while loading
        @(posedge clk); #1;
        ready = 1'b0;
        s0 = n_start; jd0 = n_jd; fi0 = n_fi;
        push_job(4, 2, 0, 0);
        apply_cfg(4, 2, 0, 0, 1, 1, 2);
        done = 1'b1;
        @(posedge clk); #1;
        done = 1'b0;
        for (k = 0; k < 200; k++) begin
            if (n_fi - fi0 >= 2) break;
            @(posedge clk); #1;
        end
        chk("holdoff_loads_done", 32'(k < 200), 32'd1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("holdoff_start_low", 32'({Start, busy}), 32'b01);
        end
        @(posedge clk); #1;
        chk("holdoff_stray_done_ignored", 32'(n_jd - jd0), 32'd0);
        ready = 1'b1;
        wait_start(s0, "holdoff");
        @(posedge clk); #1;
        chk("holdoff_single_start", 32'(n_start - s0), 32'd1);
        finish_job("holdoff");
        @(posedge clk); #1;
        chk("holdoff_total_start", 32'(n_start - s0), 32'd1);
        chk("holdoff_queues_drained", 32'(q_if.size() + q_fi.size() + q_ps.size()), 32'd0);

        repeat (3) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
